// File: rtl/divider_arbiter.sv
// Round-robin front end that shares one iterative unsigned divider among NUM_REQ requesters,
// converting signed operands to magnitudes and restoring signs on the tagged response.
module divider_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  localparam int ID_WIDTH  = $clog2(NUM_REQ)
) (
  input  logic                          clk_i,
  input  logic                          rst_n_i,
  input  logic                          clk_en_i,
  input  logic [NUM_REQ-1:0]            req_valid_i,
  output logic [NUM_REQ-1:0]            req_ready_o,
  input  logic [NUM_REQ-1:0]            req_signed_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_dividend_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_divisor_i,
  output logic [DATA_WIDTH-1:0]         div_dividend_o,
  output logic [DATA_WIDTH-1:0]         div_divisor_o,
  output logic                          div_valid_o,
  input  logic [DATA_WIDTH-1:0]         div_quotient_i,
  input  logic [DATA_WIDTH-1:0]         div_remainder_i,
  input  logic                          div_dbz_i,
  input  logic                          div_valid_i,
  output logic                          rsp_valid_o,
  input  logic                          rsp_ready_i,
  output logic [ID_WIDTH-1:0]           rsp_id_o,
  output logic [DATA_WIDTH-1:0]         rsp_quotient_o,
  output logic [DATA_WIDTH-1:0]         rsp_remainder_o,
  output logic                          rsp_dbz_o
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   job_id;
  logic                  dvd_neg_q;
  logic                  dvs_neg_q;
  logic [DATA_WIDTH-1:0] orig_dvd;

  logic                  gnt_found;
  logic [ID_WIDTH-1:0]   gnt_id;
  logic [ID_WIDTH:0]     scan;
  logic [DATA_WIDTH-1:0] sel_dvd, sel_dvs;
  logic                  sel_dvd_neg, sel_dvs_neg;
  logic [DATA_WIDTH-1:0] mag_dvd, mag_dvs;
  logic [DATA_WIDTH-1:0] fix_quo, fix_rem;

  // Scan from the round-robin pointer upward, wrapping; the first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_id    = '0;
    scan      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      scan = {1'b0, rr_ptr} + (ID_WIDTH+1)'(i);
      if (scan >= (ID_WIDTH+1)'(NUM_REQ))
        scan = scan - (ID_WIDTH+1)'(NUM_REQ);
      if (!gnt_found && req_valid_i[scan[ID_WIDTH-1:0]]) begin
        gnt_found = 1'b1;
        gnt_id    = scan[ID_WIDTH-1:0];
      end
    end
  end

  // Ready is withheld while the state cannot advance, so valid&ready always means a transfer.
  always_comb begin
    req_ready_o = '0;
    if (state == IDLE && rst_n_i && clk_en_i && gnt_found)
      req_ready_o[gnt_id] = 1'b1;
  end

  always_comb begin
    sel_dvd     = req_dividend_i[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    sel_dvs     = req_divisor_i[int'(gnt_id)*DATA_WIDTH +: DATA_WIDTH];
    sel_dvd_neg = req_signed_i[gnt_id] & sel_dvd[DATA_WIDTH-1];
    sel_dvs_neg = req_signed_i[gnt_id] & sel_dvs[DATA_WIDTH-1];
    mag_dvd     = sel_dvd_neg ? -sel_dvd : sel_dvd;
    mag_dvs     = sel_dvs_neg ? -sel_dvs : sel_dvs;
  end

  // MIN / -1 needs no special case: 2^(W-1)/1 with equal signs leaves quotient MIN, remainder 0.
  always_comb begin
    fix_quo = div_quotient_i;
    fix_rem = div_remainder_i;
    if (div_dbz_i) begin
      fix_quo = '1;
      fix_rem = orig_dvd;
    end else begin
      if (dvd_neg_q ^ dvs_neg_q) fix_quo = -div_quotient_i;
      if (dvd_neg_q)             fix_rem = -div_remainder_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state           <= IDLE;
      rr_ptr          <= '0;
      job_id          <= '0;
      dvd_neg_q       <= 1'b0;
      dvs_neg_q       <= 1'b0;
      orig_dvd        <= '0;
      div_dividend_o  <= '0;
      div_divisor_o   <= '0;
      div_valid_o     <= 1'b0;
      rsp_valid_o     <= 1'b0;
      rsp_id_o        <= '0;
      rsp_quotient_o  <= '0;
      rsp_remainder_o <= '0;
      rsp_dbz_o       <= 1'b0;
    end else if (clk_en_i) begin
      case (state)
        IDLE: begin
          if (gnt_found) begin
            job_id         <= gnt_id;
            dvd_neg_q      <= sel_dvd_neg;
            dvs_neg_q      <= sel_dvs_neg;
            orig_dvd       <= sel_dvd;
            div_dividend_o <= mag_dvd;
            div_divisor_o  <= mag_dvs;
            div_valid_o    <= 1'b1;
            rr_ptr         <= (gnt_id == ID_WIDTH'(NUM_REQ-1)) ? '0 : gnt_id + ID_WIDTH'(1);
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          div_valid_o <= 1'b0;
          state       <= WAIT;
        end
        WAIT: begin
          if (div_valid_i) begin
            rsp_valid_o     <= 1'b1;
            rsp_id_o        <= job_id;
            rsp_quotient_o  <= fix_quo;
            rsp_remainder_o <= fix_rem;
            rsp_dbz_o       <= div_dbz_i;
            state           <= RESPOND;
          end
        end
        RESPOND: begin
          if (rsp_ready_i) begin
            rsp_valid_o <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_divider_arbiter.sv
// Directed bench for divider_arbiter with a behavioural 8-cycle divider model.
module tb_divider_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;

  logic            clk_i = 1'b0;
  logic            rst_n_i, clk_en_i;
  logic [NR-1:0]   req_valid_i, req_ready_o, req_signed_i;
  logic [NR*DW-1:0] req_dividend_i, req_divisor_i;
  logic [DW-1:0]   div_dividend_o, div_divisor_o, div_quotient_i, div_remainder_i;
  logic            div_valid_o, div_dbz_i, div_valid_i;
  logic            rsp_valid_o, rsp_ready_i, rsp_dbz_o;
  logic [1:0]      rsp_id_o;
  logic [DW-1:0]   rsp_quotient_o, rsp_remainder_o;

  int total = 0;
  int bad   = 0;
  int starts = 0;
  int rsp_seen = 0;
  logic [DW-1:0] last_dvd, last_dvs;
  logic [3:0]    cnt;

  divider_arbiter #(.DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .clk_en_i(clk_en_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_signed_i(req_signed_i),
    .req_dividend_i(req_dividend_i), .req_divisor_i(req_divisor_i),
    .div_dividend_o(div_dividend_o), .div_divisor_o(div_divisor_o), .div_valid_o(div_valid_o),
    .div_quotient_i(div_quotient_i), .div_remainder_i(div_remainder_i),
    .div_dbz_i(div_dbz_i), .div_valid_i(div_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_id_o(rsp_id_o),
    .rsp_quotient_o(rsp_quotient_o), .rsp_remainder_o(rsp_remainder_o), .rsp_dbz_o(rsp_dbz_o)
  );

  always #5 clk_i = ~clk_i;

  // Shared divider stand-in: same reset and clock enable, result pulse DW cycles after start.
  always @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt <= '0;
      div_quotient_i <= '0;
      div_remainder_i <= '0;
      div_dbz_i <= 1'b0;
    end else if (clk_en_i) begin
      if (div_valid_o) begin
        cnt <= 4'(DW);
        div_dbz_i <= (div_divisor_o == 0);
        div_quotient_i <= (div_divisor_o == 0) ? '1 : div_dividend_o / div_divisor_o;
        div_remainder_i <= (div_divisor_o == 0) ? div_dividend_o : div_dividend_o % div_divisor_o;
      end else if (cnt != 0) begin
        cnt <= cnt - 4'd1;
      end
    end
  end
  assign div_valid_i = (cnt == 4'd1);

  always @(posedge clk_i) begin
    if (rst_n_i && clk_en_i && div_valid_o) begin
      starts++;
      last_dvd <= div_dividend_o;
      last_dvs <= div_divisor_o;
    end
    if (rst_n_i && rsp_valid_o) rsp_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic wait_rsp(input string tag);
    int n = 0;
    while (rsp_valid_o !== 1'b1 && n < 40) begin
      @(negedge clk_i);
      n++;
    end
    chk({tag, "_rsp_seen"}, rsp_valid_o, 1);
  endtask

  task automatic run_job(input int k, input bit sgn, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ma, input logic [7:0] mb, input logic [7:0] eq,
                         input logic [7:0] er, input bit ed, input int hold, input string tag);
    int s0;
    req_valid_i = '0;
    req_valid_i[k] = 1'b1;
    req_signed_i[k] = sgn;
    req_dividend_i[k*DW +: DW] = a;
    req_divisor_i[k*DW +: DW] = b;
    #1 chk({tag, "_grant"}, req_ready_o, 4'b0001 << k);
    s0 = starts;
    @(negedge clk_i);
    req_valid_i = '0;
    chk({tag, "_start"}, div_valid_o, 1);
    if (hold > 0) begin
      clk_en_i = 1'b0;
      repeat (hold) begin
        @(negedge clk_i);
        chk({tag, "_hold"}, div_valid_o, 1);
      end
      clk_en_i = 1'b1;
    end
    wait_rsp(tag);
    chk({tag, "_pulses"}, starts - s0, 1);
    chk({tag, "_mag_a"}, last_dvd, ma);
    chk({tag, "_mag_b"}, last_dvs, mb);
    chk({tag, "_id"}, rsp_id_o, k);
    chk({tag, "_q"}, rsp_quotient_o, eq);
    chk({tag, "_r"}, rsp_remainder_o, er);
    chk({tag, "_dbz"}, rsp_dbz_o, ed);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;
    chk({tag, "_done"}, rsp_valid_o, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  // Round-robin table: unsigned operands per requester and their results.
  logic [7:0] rr_a [4] = '{8'd100, 8'd50, 8'd255, 8'd9};
  logic [7:0] rr_b [4] = '{8'd9, 8'd7, 8'd16, 8'd10};
  logic [7:0] rr_q [4] = '{8'd11, 8'd7, 8'd15, 8'd0};
  logic [7:0] rr_r [4] = '{8'd1, 8'd1, 8'd15, 8'd9};
  int rr_order [5] = '{0, 1, 2, 3, 0};

  initial begin
    int r0, id;
    rst_n_i = 1'b0;
    clk_en_i = 1'b1;
    rsp_ready_i = 1'b0;
    req_signed_i = '0;
    req_dividend_i = '0;
    req_divisor_i = '0;
    for (int k = 0; k < NR; k++) begin
      req_dividend_i[k*DW +: DW] = rr_a[k];
      req_divisor_i[k*DW +: DW] = rr_b[k];
    end
    req_valid_i = 4'hF;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", req_ready_o, 0);
    chk("rst_div_valid", div_valid_o, 0);
    chk("rst_rsp_valid", rsp_valid_o, 0);
    chk("rst_id", rsp_id_o, 0);
    chk("rst_q", rsp_quotient_o, 0);
    chk("rst_r", rsp_remainder_o, 0);
    chk("rst_dbz", rsp_dbz_o, 0);
    chk("rst_dvd", div_dividend_o, 0);
    chk("rst_dvs", div_divisor_o, 0);
    rst_n_i = 1'b1;
    #1 chk("rr_first_grant", req_ready_o, 4'b0001);

    // All four requesters held valid; each response stalled 5 cycles.
    for (int j = 0; j < 5; j++) begin
      wait_rsp("rr");
      id = rr_order[j];
      for (int c = 0; c < 5; c++) begin
        chk("rr_id", rsp_id_o, id);
        chk("rr_q", rsp_quotient_o, rr_q[id]);
        chk("rr_r", rsp_remainder_o, rr_r[id]);
        chk("rr_dbz", rsp_dbz_o, 0);
        chk("rr_valid", rsp_valid_o, 1);
        chk("rr_pulses", starts, j + 1);
        chk("rr_ready_low", req_ready_o, 0);
        @(negedge clk_i);
      end
      rsp_ready_i = 1'b1;
      if (j == 4) req_valid_i = '0;
      @(negedge clk_i);
      rsp_ready_i = 1'b0;
      chk("rr_handshake", rsp_valid_o, 0);
    end

    run_job(1, 1'b0, 8'd200, 8'd7,  8'd200, 8'd7,  8'd28,  8'd4,  1'b0, 0, "u200_7");
    run_job(2, 1'b1, 8'hF9,  8'h02, 8'h07,  8'h02, 8'hFD,  8'hFF, 1'b0, 0, "sm7_2");
    run_job(3, 1'b1, 8'h07,  8'hFE, 8'h07,  8'h02, 8'hFD,  8'h01, 1'b0, 0, "s7_m2");
    run_job(0, 1'b1, 8'h85,  8'h00, 8'h7B,  8'h00, 8'hFF,  8'h85, 1'b1, 0, "sdbz");
    run_job(0, 1'b0, 8'h85,  8'h00, 8'h85,  8'h00, 8'hFF,  8'h85, 1'b1, 0, "udbz");
    run_job(3, 1'b1, 8'h80,  8'hFF, 8'h80,  8'h01, 8'h80,  8'h00, 1'b0, 0, "min_m1");
    run_job(1, 1'b0, 8'd20,  8'd3,  8'd20,  8'd3,  8'd6,   8'd2,  1'b0, 2, "clken");

    // Abort a job from requester 2 mid-flight; pointer would otherwise favour requester 3.
    req_signed_i = '0;
    req_dividend_i[2*DW +: DW] = 8'd50;
    req_divisor_i[2*DW +: DW] = 8'd5;
    req_valid_i = 4'b0100;
    @(negedge clk_i);
    req_valid_i = '0;
    repeat (4) @(negedge clk_i);
    rst_n_i = 1'b0;
    @(negedge clk_i);
    chk("abort_ready", req_ready_o, 0);
    chk("abort_div_valid", div_valid_o, 0);
    chk("abort_rsp_valid", rsp_valid_o, 0);
    chk("abort_id", rsp_id_o, 0);
    chk("abort_q", rsp_quotient_o, 0);
    chk("abort_r", rsp_remainder_o, 0);
    chk("abort_dbz", rsp_dbz_o, 0);
    chk("abort_dvd", div_dividend_o, 0);
    chk("abort_dvs", div_divisor_o, 0);
    rst_n_i = 1'b1;
    r0 = rsp_seen;
    repeat (20) @(negedge clk_i);
    chk("abort_no_rsp", rsp_seen - r0, 0);
    req_dividend_i[0 +: DW] = 8'd30;
    req_divisor_i[0 +: DW] = 8'd4;
    req_dividend_i[3*DW +: DW] = 8'd9;
    req_divisor_i[3*DW +: DW] = 8'd3;
    req_valid_i = 4'b1001;
    #1 chk("post_rst_grant", req_ready_o, 4'b0001);
    @(negedge clk_i);
    req_valid_i = '0;
    wait_rsp("post_rst");
    chk("post_rst_id", rsp_id_o, 0);
    chk("post_rst_q", rsp_quotient_o, 8'd7);
    chk("post_rst_r", rsp_remainder_o, 8'd2);
    rsp_ready_i = 1'b1;
    @(negedge clk_i);
    rsp_ready_i = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
